wb_initiator: RTL and testbench
===============================

# wb_initiator

Wishbone classic-cycle initiator (bus master) that turns a simple valid/ready command stream into single or incrementing-burst transfers, with one response per beat. It is the master-side counterpart of the project's Wishbone responders (`wb_logic`, `sha1_wb`). It lets on-chip logic or a logic-analyzer-driven sequencer exercise those responders without the management core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: stall cycles with STB high and no ACK before a beat is aborted. Range 1..65535.
- `ADDR_INC`, default 4: byte increment between burst beats.

Ports:
- `wb_clk_i` in 1: sole clock; all logic is on its rising edge.
- `wb_rst_ni` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_adr` in 32: start byte address.
- `cmd_dat` in 32: write data, used for every beat of the burst.
- `cmd_sel` in 4: byte selects.
- `cmd_len` in 4: beats minus 1 (0 = single, 15 = 16 beats).
- `rsp_valid` out 1: beat response present.
- `rsp_ready` in 1: response consumed when both are high.
- `rsp_dat` out 32: read data (0 for writes).
- `rsp_err` out 1: beat aborted by timeout.
- `rsp_last` out 1: final response of the command.
- `busy` out 1: high whenever the block is not IDLE.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1; `wbm_sel_o` out 4; `wbm_adr_o`, `wbm_dat_o` out 32: master bus outputs.
- `wbm_ack_i` in 1; `wbm_dat_i` in 32: responder return.

## Operation
- States are IDLE, BUS and RESP.
- IDLE:
  - `cmd_ready=1`.
  - On accept, register we/adr/dat/sel/len, clear the beat counter and go to BUS.
- BUS:
  - `cyc=stb=1`, with address = `cmd_adr + beat*ADDR_INC` (32-bit modulo, wraps silently).
  - On `wbm_ack_i`: capture `wbm_dat_i` (reads) or 0 (writes) into `rsp_dat`, set `rsp_err=0`, drop stb, go to RESP.
- RESP:
  - `rsp_valid=1`, `cyc=1`, `stb=0`.
  - On `rsp_ready`: if beat == len or an error occurred, drop cyc and go to IDLE. Otherwise increment beat and go to BUS.
  - `rsp_last=1` when beat == len or `rsp_err`=1.
- `cyc` stays high for the whole burst. Other responders see back-to-back strobes separated by RESP cycles.
- ACK arriving while stb=0 (IDLE or RESP) is ignored.
- `cmd_valid` outside IDLE is not accepted (`cmd_ready=0`).
- Reset (any time, including mid-burst): all outputs 0, state IDLE, counters 0. The bus cycle is abandoned immediately; no response is produced.

## Timing
- Command accepted at edge N: `cyc`/`stb`/adr valid after edge N (visible in cycle N+1).
- Zero-wait responder (ACK in the first STB cycle): `rsp_valid` is high from the following cycle. One cycle per BUS, at least one per RESP.
- Single-beat latency from command accept to `rsp_valid` is 2 cycles minimum.
- With `rsp_ready` held high, a burst beat takes 2 cycles, so a 16-beat burst completes in 32 cycles and returns to IDLE.
- Response holds stable while `rsp_valid && !rsp_ready`.
- `cmd_ready` re-asserts the cycle after the last response handshake.

## Configuration
- `WB_INITIATOR_TIMEOUT_EN` defined:
  - A 16-bit stall counter runs in BUS, cleared on entering BUS.
  - When the count reaches `TIMEOUT_CYCLES` without ACK, the beat is aborted:
    - stb and cyc drop at that edge;
    - RESP is entered with `rsp_err=1`, `rsp_dat=0`, `rsp_last=1`;
    - remaining beats are discarded.
  - ACK on the same edge as expiry wins: normal response.
- Macro not defined: no counter. BUS waits indefinitely, `rsp_err` is tied 0, and `TIMEOUT_CYCLES` is unused.

## Test plan
- Single write:
  - Stimulus: adr=0x3000_0000, dat=0x0000_00A5, sel=0xF, len=0; responder ACKs in the first STB cycle.
  - Response: one STB cycle with we=1 and matching adr/dat/sel; rsp_valid after 2 cycles; rsp_dat=0; rsp_last=1; rsp_err=0.
- Read burst:
  - Stimulus: adr=0x3000_0010, len=3; responder returns 0x11, 0x22, 0x33, 0x44 with 2 wait states each.
  - Response: addresses 0x10, 0x14, 0x18, 0x1C; rsp_dat in order; rsp_last on the 4th beat only; cyc continuously high.
- Backpressure:
  - Stimulus: hold `rsp_ready=0` for 5 cycles on beat 0 of a 2-beat read.
  - Response: stb=0 and rsp_dat stable throughout; beat 1 STB starts the cycle after the handshake.
- Address wrap:
  - Stimulus: adr=0xFFFF_FFFC, len=1.
  - Response: second beat address is 0x0000_0000.
- Timeout (macro on, `TIMEOUT_CYCLES=8`):
  - Stimulus: read with len=2; responder never ACKs.
  - Response: stb drops after 8 stall cycles; one response with rsp_err=1, rsp_dat=0, rsp_last=1; cmd_ready returns after the handshake.
- Reset mid-burst:
  - Stimulus: assert `wb_rst_ni=0` during beat 1 of a 4-beat write.
  - Response: cyc/stb/rsp_valid go 0 asynchronously. After release, the block is in IDLE and a new single read completes normally.

Source files
------------

// File: rtl/wb_initiator.sv
// Wishbone classic-cycle initiator: turns a valid/ready command into single or
// incrementing-burst transfers with one response per beat. Optional stall timeout: WB_INITIATOR_TIMEOUT_EN.
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ADDR_INC       = 32'd4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    input  logic [3:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic [3:0]  len_q;
    logic [3:0]  beat_q;
    logic [31:0] rsp_dat_q;
    logic        rsp_err_q;
    logic        last_beat;
    logic        in_bus;
    logic        timeout_hit;

    assign last_beat = (beat_q == len_q);
    assign in_bus    = (state == ST_BUS);

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] stall_q;

    // Counter is held at zero outside BUS, so every beat starts from a fresh count.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            stall_q <= '0;
        end else if (!in_bus) begin
            stall_q <= '0;
        end else if (!wbm_ack_i) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign timeout_hit = in_bus && !wbm_ack_i && (stall_q == STALL_LIMIT);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        we_q   <= cmd_we;
                        adr_q  <= cmd_adr;
                        dat_q  <= cmd_dat;
                        sel_q  <= cmd_sel;
                        len_q  <= cmd_len;
                        beat_q <= '0;
                        state  <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wbm_ack_i) begin
                        rsp_dat_q <= we_q ? 32'd0 : wbm_dat_i;
                        rsp_err_q <= 1'b0;
                        state     <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_dat_q <= '0;
                        rsp_err_q <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        if (last_beat || rsp_err_q) begin
                            rsp_err_q <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                            adr_q  <= adr_q + ADDR_INC;
                            state  <= ST_BUS;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_valid && (last_beat || rsp_err_q);

    // An aborted beat releases the bus at once, so cyc stays low through its RESP.
    assign wbm_cyc_o = in_bus || (rsp_valid && !rsp_err_q);
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus && we_q;
    assign wbm_sel_o = in_bus ? sel_q : 4'd0;
    assign wbm_adr_o = in_bus ? adr_q : 32'd0;
    assign wbm_dat_o = (in_bus && we_q) ? dat_q : 32'd0;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator with a small Wishbone responder
// model; the timeout scenario runs only when WB_INITIATOR_TIMEOUT_EN is defined.
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic [3:0]  cmd_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_last;
    logic        busy;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack = 1'b0;
    logic [31:0] rdat = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Responder configuration and bookkeeping
    int          resp_wait = 0;
    bit          resp_never = 1'b0;
    int          wcnt = 0;
    logic [31:0] rd_q[$];
    logic [31:0] seen_adr[$];

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT_CYCLES(8), .ADDR_INC(32'd4)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat)
    );

    // ACK after resp_wait stall cycles; reads pop data from rd_q, writes return junk
    always @(negedge clk) begin
        if (!rst_n || !stb || resp_never) begin
            ack  = 1'b0;
            wcnt = 0;
        end else if (ack) begin
            ack  = 1'b0;
            wcnt = 0;
        end else if (wcnt == resp_wait) begin
            ack  = 1'b1;
            rdat = (!we && rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
        end else begin
            wcnt++;
        end
    end

    always @(posedge clk) begin
        if (stb && ack) seen_adr.push_back(adr);
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_len = l;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int i;
        for (i = 0; i < 60 && !rsp_valid; i++) @(negedge clk);
        n_cmp++;
        if (!rsp_valid) begin
            n_bad++;
            $display("FAIL %s: rsp_valid never arrived (got %b, want 1)", name, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cyc, stb, we, rsp_valid, rsp_err, rsp_last, busy} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b, want 0000000", {cyc, stb, we, rsp_valid, rsp_err, rsp_last, busy});
        end
        n_cmp++;
        if ({adr, wdat, rsp_dat, sel} !== 100'd0) begin
            n_bad++;
            $display("FAIL reset_data: adr=%h dat=%h rsp_dat=%h sel=%h, want all 0", adr, wdat, rsp_dat, sel);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_cmd_ready: got %b, want 1", cmd_ready);
        end
    endtask

    task automatic test_single_write();
        resp_wait = 0; rsp_ready = 1'b1;
        issue(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF, 4'd0);
        n_cmp++;
        if ({stb, cyc, we, sel, adr, wdat, rsp_valid} !== {3'b111, 4'hF, 32'h3000_0000, 32'hA5, 1'b0}) begin
            n_bad++;
            $display("FAIL wr_bus: stb=%b cyc=%b we=%b sel=%h adr=%h dat=%h rv=%b, want 1 1 1 f 30000000 000000a5 0",
                     stb, cyc, we, sel, adr, wdat, rsp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_dat, rsp_last, rsp_err, stb, cyc} !== {1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL wr_rsp: valid=%b dat=%h last=%b err=%b stb=%b cyc=%b, want 1 0 1 0 0 1",
                     rsp_valid, rsp_dat, rsp_last, rsp_err, stb, cyc);
        end
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, cyc, rsp_valid} !== 4'b1000) begin
            n_bad++;
            $display("FAIL wr_done: ready/busy/cyc/rv=%b, want 1000", {cmd_ready, busy, cyc, rsp_valid});
        end
    endtask

    task automatic test_read_burst();
        logic [31:0] exp_d[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        bit cyc_drop = 1'b0;
        resp_wait = 2; rsp_ready = 1'b1;
        seen_adr.delete();
        for (int i = 0; i < 4; i++) rd_q.push_back(exp_d[i]);
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, 4'd3);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 20 && !rsp_valid; i++) begin
                if (!cyc) cyc_drop = 1'b1;
                @(negedge clk);
            end
            wait_rsp("rd_burst_wait");
            if (!cyc) cyc_drop = 1'b1;
            n_cmp++;
            if (rsp_dat !== exp_d[b] || rsp_last !== (b == 3) || rsp_err !== 1'b0) begin
                n_bad++;
                $display("FAIL rd_beat%0d: dat=%h last=%b err=%b, want %h %b 0",
                         b, rsp_dat, rsp_last, rsp_err, exp_d[b], (b == 3));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (cyc_drop) begin
            n_bad++;
            $display("FAIL rd_cyc_hold: cyc dropped mid-burst (got 1 drop, want 0)");
        end
        n_cmp++;
        if (seen_adr.size() != 4 || seen_adr[0] !== 32'h3000_0010 || seen_adr[1] !== 32'h3000_0014 ||
            seen_adr[2] !== 32'h3000_0018 || seen_adr[3] !== 32'h3000_001C) begin
            n_bad++;
            $display("FAIL rd_addrs: got %p, want 30000010 30000014 30000018 3000001c", seen_adr);
        end
    endtask

    task automatic test_backpressure();
        bit unstable = 1'b0;
        resp_wait = 0; rsp_ready = 1'b0;
        rd_q.push_back(32'hAA); rd_q.push_back(32'hBB);
        issue(1'b0, 32'h3000_0100, 32'h0, 4'hF, 4'd1);
        wait_rsp("bp_wait");
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || stb || rsp_dat !== 32'hAA || !cyc) unstable = 1'b1;
            if (i == 4) rsp_ready = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (unstable) begin
            n_bad++;
            $display("FAIL bp_hold: response changed under backpressure (got unstable, want stable aa)");
        end
        @(negedge clk);
        n_cmp++;
        if ({stb, rsp_valid, adr} !== {2'b10, 32'h3000_0104}) begin
            n_bad++;
            $display("FAIL bp_beat1_stb: stb=%b rv=%b adr=%h, want 1 0 30000104", stb, rsp_valid, adr);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_dat, rsp_last} !== {1'b1, 32'hBB, 1'b1}) begin
            n_bad++;
            $display("FAIL bp_beat1_rsp: rv=%b dat=%h last=%b, want 1 bb 1", rsp_valid, rsp_dat, rsp_last);
        end
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_ready: cmd_ready=%b, want 1", cmd_ready);
        end
    endtask

    task automatic test_addr_wrap();
        resp_wait = 0; rsp_ready = 1'b1;
        seen_adr.delete();
        issue(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'h3, 4'd1);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (seen_adr.size() != 2 || seen_adr[0] !== 32'hFFFF_FFFC || seen_adr[1] !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL wrap_addrs: got %p, want fffffffc 00000000", seen_adr);
        end
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL wrap_done: ready/busy=%b, want 10", {cmd_ready, busy});
        end
    endtask

`ifdef WB_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        int stb_cycles = 0;
        resp_never = 1'b1; rsp_ready = 1'b1;
        issue(1'b0, 32'h3000_0200, 32'h0, 4'hF, 4'd2);
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            if (stb) stb_cycles++;
            @(negedge clk);
        end
        n_cmp++;
        if (stb_cycles != 8) begin
            n_bad++;
            $display("FAIL to_stall_len: stb high %0d cycles, want 8", stb_cycles);
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_dat, rsp_last, stb, cyc} !== {1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL to_rsp: rv=%b err=%b dat=%h last=%b stb=%b cyc=%b, want 1 1 0 1 0 0",
                     rsp_valid, rsp_err, rsp_dat, rsp_last, stb, cyc);
        end
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, rsp_valid, stb, cyc} !== 4'b1000) begin
            n_bad++;
            $display("FAIL to_done: ready/rv/stb/cyc=%b, want 1000", {cmd_ready, rsp_valid, stb, cyc});
        end
        resp_never = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_burst();
        resp_wait = 1; rsp_ready = 1'b1;
        issue(1'b1, 32'h3000_0300, 32'hCAFE_0001, 4'hF, 4'd3);
        wait_rsp("rst_beat0_wait");
        @(negedge clk);
        n_cmp++;
        if (stb !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_beat1_stb: stb=%b, want 1", stb);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cyc, stb, rsp_valid, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_async: cyc/stb/rv/busy=%b, want 0000", {cyc, stb, rsp_valid, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, cyc, rsp_valid} !== 4'b1000) begin
            n_bad++;
            $display("FAIL rst_idle: ready/busy/cyc/rv=%b, want 1000", {cmd_ready, busy, cyc, rsp_valid});
        end
        resp_wait = 0;
        rd_q.delete();
        rd_q.push_back(32'h5A5A_1234);
        issue(1'b0, 32'h3000_0400, 32'h0, 4'hF, 4'd0);
        wait_rsp("rst_read_wait");
        n_cmp++;
        if ({rsp_dat, rsp_last, rsp_err} !== {32'h5A5A_1234, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_read: dat=%h last=%b err=%b, want 5a5a1234 1 0", rsp_dat, rsp_last, rsp_err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_backpressure();
        test_addr_wrap();
`ifdef WB_INITIATOR_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (got hang, want done)");
        $fatal(1);
    end

endmodule
